// File: rtl/comparator_seq_ctrl.sv
// Comparator sequencer: power up, settle, take NSAMP synchronized samples, majority vote, one-shot or periodic.
// Optional macro CMP_DEBOUNCE_EN: a decision is accepted only when two consecutive conversions agree.
module comparator_seq_ctrl #(
  parameter int NSAMP       = 5,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_W    = 8,
  parameter int PERIOD_W    = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                periodic_i,
  input  logic [SETTLE_W-1:0] settle_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                cmp_i,
  output logic                cmp_en_o,
  output logic                cmp_latch_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                result_o,
  output logic                result_valid_o,
  output logic                irq_o
);

  localparam int CNT_W = $clog2(NSAMP + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_WAIT} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SETTLE_W-1:0]    r_scnt;
  logic [PERIOD_W-1:0]    r_pcnt;
  logic [CNT_W-1:0]       r_ones;
  logic [CNT_W-1:0]       r_idx;
  logic                   r_cmp_en;
  logic                   r_latch;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_result;
  logic                   r_valid;
  logic                   r_irq;

  logic                   w_cmp_s;
  logic                   w_last;
  logic [SUM_W-1:0]       w_sum;
  logic                   w_dec;
  logic                   w_accept;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], cmp_i};
  end

  assign w_cmp_s = r_sync[SYNC_STAGES-1];
  assign w_last  = (r_idx == CNT_W'(NSAMP - 1));
  // The final sample is folded in combinationally so the vote lands on the same edge.
  assign w_sum   = {1'b0, r_ones} + {{CNT_W{1'b0}}, w_cmp_s};
  assign w_dec   = (w_sum > SUM_W'(NSAMP / 2));

`ifdef CMP_DEBOUNCE_EN
  logic r_prev_dec;
  assign w_accept = (w_dec == r_prev_dec);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || abort_i)               r_prev_dec <= 1'b0;
    else if (r_state == S_SAMPLE && w_last) r_prev_dec <= w_dec;
  end
`else
  assign w_accept = 1'b1;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      r_scnt   <= '0;
      r_pcnt   <= '0;
      r_ones   <= '0;
      r_idx    <= '0;
      r_cmp_en <= 1'b0;
      r_latch  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 1'b0;
      r_valid  <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_irq  <= 1'b0;
      if (abort_i) begin
        r_state  <= S_IDLE;
        r_ones   <= '0;
        r_idx    <= '0;
        r_cmp_en <= 1'b0;
        r_latch  <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_state  <= S_SETTLE;
              r_scnt   <= settle_i;
              r_cmp_en <= 1'b1;
              r_busy   <= 1'b1;
            end
          end
          S_SETTLE: begin
            if (r_scnt == '0) begin
              r_state <= S_SAMPLE;
              r_latch <= 1'b1;
            end else begin
              r_scnt <= r_scnt - SETTLE_W'(1);
            end
          end
          S_SAMPLE: begin
            if (w_last) begin
              r_ones  <= '0;
              r_idx   <= '0;
              r_done  <= 1'b1;
              r_valid <= 1'b1;
              r_latch <= 1'b0;
              if (w_accept) begin
                r_result <= w_dec;
                r_irq    <= (w_dec != r_result);
              end
              r_cmp_en <= 1'b0;
              if (periodic_i) begin
                r_state <= S_WAIT;
                r_pcnt  <= period_i;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_ones <= r_ones + CNT_W'(w_cmp_s);
              r_idx  <= r_idx + CNT_W'(1);
            end
          end
          S_WAIT: begin
            if (!periodic_i) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else if (r_pcnt == '0) begin
              r_state  <= S_SETTLE;
              r_scnt   <= settle_i;
              r_cmp_en <= 1'b1;
            end else begin
              r_pcnt <= r_pcnt - PERIOD_W'(1);
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_cmp_en <= 1'b0;
            r_latch  <= 1'b0;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cmp_en_o       = r_cmp_en;
  assign cmp_latch_o    = r_latch;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign result_o       = r_result;
  assign result_valid_o = r_valid;
  assign irq_o          = r_irq;

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// Bench for comparator_seq_ctrl: timeline-based reference model checked every cycle, plus directed literal checks.
module tb_comparator_seq_ctrl;

  localparam int NSAMP    = 5;
  localparam int SS       = 2;
  localparam int SETTLE_W = 8;
  localparam int PERIOD_W = 16;
  localparam int MAXC     = 40000;

  logic                clk = 1'b0;
  logic                rst;
  logic                start_i;
  logic                abort_i;
  logic                periodic_i;
  logic [SETTLE_W-1:0] settle_i;
  logic [PERIOD_W-1:0] period_i;
  logic                cmp_i;
  logic                cmp_en_o;
  logic                cmp_latch_o;
  logic                busy_o;
  logic                done_o;
  logic                result_o;
  logic                result_valid_o;
  logic                irq_o;

  always #5 clk = ~clk;

  comparator_seq_ctrl #(
    .NSAMP(NSAMP), .SYNC_STAGES(SS), .SETTLE_W(SETTLE_W), .PERIOD_W(PERIOD_W)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .abort_i(abort_i),
    .periodic_i(periodic_i), .settle_i(settle_i), .period_i(period_i), .cmp_i(cmp_i),
    .cmp_en_o(cmp_en_o), .cmp_latch_o(cmp_latch_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .result_valid_o(result_valid_o), .irq_o(irq_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rst = -100;
  bit raw [0:MAXC-1];

  // Model: mode 0 = idle, 1 = converting since edge m_t0, 2 = waiting since edge m_tw.
  int m_mode = 0;
  int m_t0 = 0, m_S = 0, m_tw = 0, m_P = 0;
  bit m_en = 0, m_latch = 0, m_busy = 0, m_done = 0, m_result = 0, m_valid = 0, m_irq = 0, m_prev = 0;

  int done_cnt = 0;
  int done_edge = -1;
  bit done_res = 0, done_irq = 0;

  // Synchronized comparator value seen by the design at edge e.
  function automatic bit cmp_s_at(int e);
    if (e - SS <= last_rst) return 1'b0;
    return raw[e - SS];
  endfunction

  task automatic finish_conv();
    int ones;
    bit dec, acc;
    ones = 0;
    for (int e = m_t0 + m_S + 2; e <= cyc; e++) ones += int'(cmp_s_at(e));
    dec = (ones > NSAMP / 2);
`ifdef CMP_DEBOUNCE_EN
    acc = (dec == m_prev);
    m_prev = dec;
`else
    acc = 1'b1;
`endif
    if (acc) begin
      m_irq    = (dec != m_result);
      m_result = dec;
    end
    m_done  = 1'b1;
    m_valid = 1'b1;
    if (periodic_i) begin
      m_mode = 2; m_tw = cyc; m_P = int'(period_i);
    end else begin
      m_mode = 0;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    raw[cyc] = cmp_i;
    m_done = 1'b0;
    m_irq  = 1'b0;
    if (rst) begin
      last_rst = cyc; m_mode = 0; m_result = 0; m_valid = 0; m_prev = 0;
    end else if (abort_i) begin
      m_mode = 0; m_prev = 0;
    end else begin
      case (m_mode)
        0: if (start_i) begin m_mode = 1; m_t0 = cyc; m_S = int'(settle_i); end
        1: if (cyc - m_t0 == m_S + NSAMP + 1) finish_conv();
        default: begin
          if (!periodic_i) m_mode = 0;
          else if (cyc - m_tw == m_P + 1) begin m_mode = 1; m_t0 = cyc; m_S = int'(settle_i); end
        end
      endcase
    end
    m_en    = (m_mode == 1);
    m_latch = (m_mode == 1) && (cyc - m_t0 > m_S);
    m_busy  = (m_mode != 0);
    #2;
    checks++;
    if ({cmp_en_o, cmp_latch_o, busy_o, done_o, result_o, result_valid_o, irq_o} !==
        {m_en, m_latch, m_busy, m_done, m_result, m_valid, m_irq}) begin
      errors++;
      $display("FAIL cycle_outputs edge %0d en/latch/busy/done/res/valid/irq got %b%b%b%b%b%b%b expected %b%b%b%b%b%b%b",
               cyc, cmp_en_o, cmp_latch_o, busy_o, done_o, result_o, result_valid_o, irq_o,
               m_en, m_latch, m_busy, m_done, m_result, m_valid, m_irq);
    end
    if (done_o === 1'b1) begin
      done_cnt++; done_edge = cyc; done_res = result_o; done_irq = irq_o;
      $display("conversion done at edge %0d result=%0d irq=%0d", cyc, result_o, irq_o);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Start a conversion with settle s; pat[j] is the j-th sample the design must see after synchronization.
  task automatic run_conv(input int s, input logic [NSAMP-1:0] pat, output int k);
    int j;
    @(negedge clk);
    k = cyc + 1;
    settle_i = SETTLE_W'(s);
    start_i = 1'b1;
    for (int e = k; e <= k + s + NSAMP + 1; e++) begin
      if (e != k) begin
        @(negedge clk);
        start_i = 1'b0;
      end
      j = e - (k + s + 2 - SS);
      if (j >= 0 && j < NSAMP) cmp_i = pat[j];
    end
    @(negedge clk);
  endtask

  int k;
  int d_before;
  int pedges[$];
  logic [NSAMP-1:0] pats [4];
  int exp_res [4];
  int exp_irq [4];

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; periodic_i = 1'b0;
    cmp_i = 1'b0; settle_i = '0; period_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_busy", int'(busy_o), 0);
    chk("idle_cmp_en", int'(cmp_en_o), 0);
    chk("idle_valid", int'(result_valid_o), 0);
    chk("idle_result", int'(result_o), 0);

    // Conversions yielding 1,0,1,1.
    pats[0] = 5'b11111; pats[1] = 5'b00101; pats[2] = 5'b01011; pats[3] = 5'b11111;
`ifdef CMP_DEBOUNCE_EN
    exp_res = '{0, 0, 0, 1}; exp_irq = '{0, 0, 0, 1};
`else
    exp_res = '{1, 0, 1, 1}; exp_irq = '{1, 1, 1, 0};
`endif
    cmp_i = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      d_before = done_cnt;
      run_conv(3, pats[i], k);
      chk($sformatf("conv%0d_done_count", i), done_cnt - d_before, 1);
      chk($sformatf("conv%0d_done_edge", i), done_edge, k + 9);
      chk($sformatf("conv%0d_result", i), int'(done_res), exp_res[i]);
      chk($sformatf("conv%0d_irq", i), int'(done_irq), exp_irq[i]);
      chk($sformatf("conv%0d_model_result", i), int'(m_result), exp_res[i]);
      chk($sformatf("conv%0d_busy_after", i), int'(busy_o), 0);
    end
    chk("valid_sticky", int'(result_valid_o), 1);

    // Periodic: settle 0, period 10 -> one done every 17 cycles.
    @(negedge clk);
    cmp_i = 1'b1; periodic_i = 1'b1; settle_i = '0; period_i = PERIOD_W'(10); start_i = 1'b1;
    d_before = done_cnt;
    @(negedge clk);
    start_i = 1'b0;
    for (int t = 0; t < 60 && pedges.size() < 2; t++) begin
      @(negedge clk);
      if (done_cnt != d_before) begin pedges.push_back(done_edge); d_before = done_cnt; end
    end
    chk("periodic_done_seen", pedges.size(), 2);
    if (pedges.size() == 2) chk("periodic_gap", pedges[1] - pedges[0], 17);
    repeat (3) @(negedge clk);
    chk("periodic_in_wait_en", int'(cmp_en_o), 0);
    chk("periodic_in_wait_busy", int'(busy_o), 1);
    periodic_i = 1'b0;
    @(negedge clk);
    chk("periodic_stop_busy", int'(busy_o), 0);
    d_before = done_cnt;
    repeat (40) @(negedge clk);
    chk("periodic_stop_no_done", done_cnt - d_before, 0);

    // Abort at the second sample cycle of a conversion that would read 0.
    @(negedge clk);
    k = cyc + 1; settle_i = SETTLE_W'(2); cmp_i = 1'b0; start_i = 1'b1;
    d_before = done_cnt;
    @(negedge clk);
    start_i = 1'b0;
    while (cyc + 1 < k + 2 + 3) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_cmp_en", int'(cmp_en_o), 0);
    chk("abort_latch", int'(cmp_latch_o), 0);
    chk("abort_busy", int'(busy_o), 0);
    repeat (15) @(negedge clk);
    chk("abort_no_done", done_cnt - d_before, 0);
    chk("abort_result_held", int'(result_o), 1);
    run_conv(1, 5'b00000, k);
    chk("after_abort_done_edge", done_edge, k + 1 + NSAMP + 1);
    chk("after_abort_result", int'(done_res), 0);
    chk("after_abort_irq", int'(done_irq), 1);

    // Abort together with start in idle stays idle.
    @(negedge clk);
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    chk("abort_start_idle", int'(busy_o), 0);

    // Random traffic, including occasional mid-conversion resets.
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 599) == 0);
      start_i    = ($urandom_range(0, 7) == 0);
      abort_i    = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 59) == 0) periodic_i = ~periodic_i;
      if ($urandom_range(0, 2) == 0) cmp_i = $urandom_range(0, 1);
      settle_i   = SETTLE_W'($urandom_range(0, 6));
      period_i   = PERIOD_W'($urandom_range(0, 8));
    end
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
